// File: rtl/srv_constant.sv
// Shared constants and FSM encodings for the srv BIU.
// AXI attribute values and the non-cacheable fetch FSM states.
package srv_constant;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam logic [2:0] AXI_PROT_INSTR = 3'b100;
  localparam logic [7:0] AXI_LEN_1      = 8'd0;
  localparam logic [3:0] AXI_CACHE_DEV  = 4'b0000;

  typedef enum logic [1:0] {
    NC_IDLE = 2'd0,
    NC_AR   = 2'd1,
    NC_R    = 2'd2,
    NC_RESP = 2'd3
  } nc_state_e;
endpackage

// File: rtl/srv_parameter.sv
// Shared build parameters for the srv core.
// AXI ID width used by every BIU master port.
package srv_parameter;
  localparam int AXI_IW = 4;
endpackage

// File: rtl/srv_biu_ifu_nc.sv
// BIU responder for IFU non-cacheable fetches.
// Each command becomes one single-beat AXI4 read.
module srv_biu_ifu_nc
  import srv_parameter::*;
  import srv_constant::*;
#(
  parameter logic [AXI_IW-1:0] NC_ARID = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ifu_biu_nc_cmd_valid,
  output logic              ifu_biu_nc_cmd_ready,
  input  logic [31:0]       ifu_biu_nc_cmd_addr,
  output logic              ifu_biu_nc_resp_valid,
  input  logic              ifu_biu_nc_resp_ready,
  output logic [63:0]       ifu_biu_nc_resp_rdata,
  output logic              ifu_biu_nc_resp_err,
  output logic [AXI_IW-1:0] biu_nc_arid,
  output logic [31:0]       biu_nc_araddr,
  output logic [7:0]        biu_nc_arlen,
  output logic [2:0]        biu_nc_arsize,
  output logic [1:0]        biu_nc_arburst,
  output logic              biu_nc_arlock,
  output logic [3:0]        biu_nc_arcache,
  output logic [2:0]        biu_nc_arprot,
  output logic              biu_nc_arvalid,
  input  logic              biu_nc_arready,
  input  logic [AXI_IW-1:0] biu_nc_rid,
  input  logic [63:0]       biu_nc_rdata,
  input  logic [1:0]        biu_nc_rresp,
  input  logic              biu_nc_rlast,
  input  logic              biu_nc_rvalid,
  output logic              biu_nc_rready
);

  nc_state_e   state_q, state_d;
  logic [31:3] addr_q, addr_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      NC_IDLE: begin
        if (ifu_biu_nc_cmd_valid) begin
          addr_d  = ifu_biu_nc_cmd_addr[31:3];
          state_d = NC_AR;
        end
      end
      NC_AR: begin
        if (biu_nc_arready) state_d = NC_R;
      end
      NC_R: begin
        if (biu_nc_rvalid) begin
          rdata_d = biu_nc_rdata;
          // SLVERR and DECERR both have bit 1 set
          err_d   = biu_nc_rresp[1];
          state_d = NC_RESP;
        end
      end
      NC_RESP: begin
        if (ifu_biu_nc_resp_ready) state_d = NC_IDLE;
      end
      default: state_d = NC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= NC_IDLE;
      addr_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign ifu_biu_nc_cmd_ready  = (state_q == NC_IDLE);
  assign biu_nc_arvalid        = (state_q == NC_AR);
  assign biu_nc_rready         = (state_q == NC_R);
  assign ifu_biu_nc_resp_valid = (state_q == NC_RESP);
  assign ifu_biu_nc_resp_rdata = rdata_q;
  assign ifu_biu_nc_resp_err   = err_q;

  assign biu_nc_araddr  = {addr_q, 3'b000};
  assign biu_nc_arid    = NC_ARID;
  assign biu_nc_arlen   = AXI_LEN_1;
  assign biu_nc_arsize  = AXI_SIZE_8B;
  assign biu_nc_arburst = AXI_BURST_INCR;
  assign biu_nc_arlock  = 1'b0;
  assign biu_nc_arcache = AXI_CACHE_DEV;
  assign biu_nc_arprot  = AXI_PROT_INSTR;

  logic unused_ok;
  assign unused_ok = ^{biu_nc_rid, biu_nc_rlast, biu_nc_rresp[0]};

endmodule

// File: tb/tb_srv_biu_ifu_nc.sv
// Bench for srv_biu_ifu_nc: directed scenarios plus random traffic.
// A transaction-level model predicts every output each cycle.
module tb_srv_biu_ifu_nc;
  import srv_parameter::*;

  localparam logic [AXI_IW-1:0] ARID = 5;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [31:0]       cmd_addr = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [63:0]       resp_rdata;
  logic              resp_err;
  logic [AXI_IW-1:0] arid;
  logic [31:0]       araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready = 1'b0;
  logic [AXI_IW-1:0] rid = '0;
  logic [63:0]       rdata = '0;
  logic [1:0]        rresp = '0;
  logic              rlast = 1'b1;
  logic              rvalid = 1'b0;
  logic              rready;

  always #5 clk = ~clk;

  srv_biu_ifu_nc #(.NC_ARID(ARID)) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .ifu_biu_nc_cmd_valid  (cmd_valid),
    .ifu_biu_nc_cmd_ready  (cmd_ready),
    .ifu_biu_nc_cmd_addr   (cmd_addr),
    .ifu_biu_nc_resp_valid (resp_valid),
    .ifu_biu_nc_resp_ready (resp_ready),
    .ifu_biu_nc_resp_rdata (resp_rdata),
    .ifu_biu_nc_resp_err   (resp_err),
    .biu_nc_arid           (arid),
    .biu_nc_araddr         (araddr),
    .biu_nc_arlen          (arlen),
    .biu_nc_arsize         (arsize),
    .biu_nc_arburst        (arburst),
    .biu_nc_arlock         (arlock),
    .biu_nc_arcache        (arcache),
    .biu_nc_arprot         (arprot),
    .biu_nc_arvalid        (arvalid),
    .biu_nc_arready        (arready),
    .biu_nc_rid            (rid),
    .biu_nc_rdata          (rdata),
    .biu_nc_rresp          (rresp),
    .biu_nc_rlast          (rlast),
    .biu_nc_rvalid         (rvalid),
    .biu_nc_rready         (rready)
  );

  int n_chk = 0;
  int n_fail = 0;

  // transaction-level model: one fetch, with its progress flags
  bit          m_active;
  bit          m_ar_done;
  bit          m_r_done;
  logic [31:0] m_addr;
  logic [63:0] m_data;
  logic        m_err;

  // outputs as sampled in the last cycle
  logic [31:0] s_araddr;
  logic [63:0] s_rdata;
  logic        s_err, s_rv, s_cr, s_av;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active  = 0;
    m_ar_done = 0;
    m_r_done  = 0;
  endtask

  task automatic check_reset_vals();
    chk("rst cmd_ready", cmd_ready, 1);
    chk("rst arvalid", arvalid, 0);
    chk("rst rready", rready, 0);
    chk("rst resp_valid", resp_valid, 0);
    chk("rst resp_err", resp_err, 0);
    chk("rst araddr", araddr, 0);
    chk("rst resp_rdata", resp_rdata, 0);
  endtask

  task automatic check_outputs();
    bit e_av, e_rr, e_rv;
    e_av = m_active && !m_ar_done;
    e_rr = m_active && m_ar_done && !m_r_done;
    e_rv = m_active && m_r_done;
    chk("cmd_ready", cmd_ready, !m_active);
    chk("arvalid", arvalid, e_av);
    chk("rready", rready, e_rr);
    chk("resp_valid", resp_valid, e_rv);
    chk("ar const", {arid, arlen, arsize, arburst, arlock, arcache, arprot},
        {ARID, 8'd0, 3'b011, 2'b01, 1'b0, 4'b0000, 3'b100});
    if (e_av) chk("araddr", araddr, {m_addr[31:3], 3'b000});
    if (e_rv) begin
      chk("resp_rdata", resp_rdata, m_data);
      chk("resp_err", resp_err, m_err);
    end
  endtask

  task automatic cyc(input logic cv, input logic [31:0] ca,
                     input logic arr, input logic rv,
                     input logic [63:0] rd, input logic [1:0] rr,
                     input logic rsr);
    bit f_cmd, f_ar, f_r, f_resp;
    @(negedge clk);
    cmd_valid  = cv;
    cmd_addr   = ca;
    arready    = arr;
    rvalid     = rv;
    rdata      = rd;
    rresp      = rr;
    resp_ready = rsr;
    #1;
    check_outputs();
    s_araddr = araddr;
    s_rdata  = resp_rdata;
    s_err    = resp_err;
    s_rv     = resp_valid;
    s_cr     = cmd_ready;
    s_av     = arvalid;
    f_cmd  = !m_active && cv;
    f_ar   = m_active && !m_ar_done && arr;
    f_r    = m_active && m_ar_done && !m_r_done && rv;
    f_resp = m_active && m_r_done && rsr;
    @(posedge clk);
    if (f_cmd) begin
      m_active  = 1;
      m_ar_done = 0;
      m_r_done  = 0;
      m_addr    = ca;
    end
    if (f_ar) m_ar_done = 1;
    if (f_r) begin
      m_r_done = 1;
      m_data   = rd;
      m_err    = rr[1];
    end
    if (f_resp) model_reset();
  endtask

  task automatic idle_cyc();
    cyc(0, 32'h0, 0, 0, 64'h0, 2'b00, 0);
  endtask

  task automatic txn(input logic [31:0] a, input logic [63:0] d,
                     input logic [1:0] rr);
    cyc(1, a, 0, 0, 64'h0, 2'b00, 0);
    cyc(0, 0, 1, 0, 64'h0, 2'b00, 0);
    cyc(0, 0, 0, 1, d, rr, 0);
    cyc(0, 0, 0, 0, 64'h0, 2'b00, 1);
  endtask

  logic [31:0] stall_addr;
  logic        err_exp [3] = '{1'b1, 1'b1, 1'b0};
  logic [1:0]  rr_set [3] = '{2'b10, 2'b11, 2'b01};

  initial begin
    model_reset();
    #12;
    check_reset_vals();
    @(negedge clk);
    reset_n = 1'b1;

    // basic fetch: stray rvalid in IDLE/AR must be ignored
    cyc(1, 32'h8000_0014, 1, 1, 64'hdead, 2'b00, 0);
    cyc(0, 0, 1, 1, 64'hbeef, 2'b10, 0);
    chk("lit araddr", s_araddr, 32'h8000_0010);
    cyc(0, 0, 0, 1, 64'h1122334455667788, 2'b00, 0);
    cyc(0, 0, 0, 0, 64'h0, 2'b00, 1);
    chk("lit resp_valid", s_rv, 1);
    chk("lit rdata", s_rdata, 64'h1122334455667788);
    chk("lit err", s_err, 0);
    idle_cyc();
    chk("lit idle cmd_ready", s_cr, 1);

    // AR stall for 5 cycles
    cyc(1, 32'h1234_567f, 0, 0, 64'h0, 2'b00, 0);
    cyc(1, 32'hffff_ffff, 0, 0, 64'h0, 2'b00, 0);
    stall_addr = s_araddr;
    chk("lit stall araddr", stall_addr, 32'h1234_5678);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 32'hffff_ffff, 0, 1, 64'h0, 2'b00, 1);
      chk("lit stall hold", {s_av, s_cr, s_araddr}, {1'b1, 1'b0, stall_addr});
    end
    cyc(0, 0, 1, 0, 64'h0, 2'b00, 0);
    cyc(0, 0, 0, 1, 64'h55, 2'b00, 0);
    cyc(0, 0, 0, 0, 64'h0, 2'b00, 1);

    // error responses
    for (int i = 0; i < 3; i++) begin
      txn(32'h0000_1000 + 32'(i * 8), 64'(i + 7), rr_set[i]);
      chk("lit err resp", s_err, err_exp[i]);
    end

    // response back-pressure with cmd_valid held high
    cyc(1, 32'h2000_0008, 1, 0, 64'h0, 2'b00, 0);
    cyc(1, 32'h3000_0000, 1, 0, 64'h0, 2'b00, 0);
    cyc(1, 32'h3000_0000, 0, 1, 64'hcafe_f00d_0bad_beef, 2'b11, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 32'h3000_0000, 0, 0, 64'h0, 2'b00, 0);
      chk("lit bp hold", {s_rv, s_err, s_rdata},
          {1'b1, 1'b1, 64'hcafe_f00d_0bad_beef});
    end
    cyc(1, 32'h3000_0000, 0, 0, 64'h0, 2'b00, 1);
    chk("lit bp no accept", s_cr, 0);
    cyc(1, 32'h3000_0000, 0, 0, 64'h0, 2'b00, 0);
    chk("lit bp accept next", s_cr, 1);
    cyc(0, 0, 1, 0, 64'h0, 2'b00, 0);
    cyc(0, 0, 0, 1, 64'h9, 2'b00, 0);
    cyc(0, 0, 0, 0, 64'h0, 2'b00, 1);

    // reset while waiting in R
    cyc(1, 32'h4000_0040, 1, 0, 64'h0, 2'b00, 0);
    cyc(0, 0, 1, 0, 64'h0, 2'b00, 0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_vals();
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 1, 64'h77, 2'b00, 1);
      chk("lit post-rst no resp", {s_rv, rready}, 2'b00);
    end

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 1), $urandom, $urandom_range(0, 1),
          $urandom_range(0, 1), {$urandom, $urandom},
          2'($urandom_range(0, 3)), $urandom_range(0, 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/srv_biu_ifu_nc.md
SRV_BIU_IFU_NC -- requirements
Module: srv_biu_ifu_nc

Interface
REQ-001 SHALL have parameter NC_ARID, default 0, meaning the AXI ID driven on every non-cacheable fetch read.
REQ-002 SHALL have ports, in this order:
  clk  input  1  single clock for all logic, rising edge.
  reset_n  input  1  asynchronous, active-low reset.
  ifu_biu_nc_cmd_valid  input  1  fetch command valid, from the IFU.
  ifu_biu_nc_cmd_ready  output  1  command accepted.
  ifu_biu_nc_cmd_addr  input  32  fetch byte address.
  ifu_biu_nc_resp_valid  output  1  response valid, to the IFU.
  ifu_biu_nc_resp_ready  input  1  IFU accepts the response.
  ifu_biu_nc_resp_rdata  output  64  fetched doubleword.
  ifu_biu_nc_resp_err  output  1  bus error on the fetch.
  biu_nc_arid  output  AXI_IW  read ID.
  biu_nc_araddr  output  32  read address.
  biu_nc_arlen  output  8  burst length.
  biu_nc_arsize  output  3  beat size.
  biu_nc_arburst  output  2  burst type.
  biu_nc_arlock  output  1  lock.
  biu_nc_arcache  output  4  cache attributes.
  biu_nc_arprot  output  3  protection attributes.
  biu_nc_arvalid  output  1  AR valid.
  biu_nc_arready  input  1  AR ready.
  biu_nc_rid  input  AXI_IW  R ID, unused.
  biu_nc_rdata  input  64  read data.
  biu_nc_rresp  input  2  read response.
  biu_nc_rlast  input  1  last beat.
  biu_nc_rvalid  input  1  R valid.
  biu_nc_rready  output  1  R ready.
REQ-003 SHALL use one clock (clk) and an asynchronous, active-low reset (reset_n).

Function
REQ-004 SHALL be the BIU-side responder for the IFU non-cacheable cmd/resp interface, converting each command into exactly one single-beat AXI4 read.
REQ-005 SHALL implement FSM states IDLE, AR, R, RESP; one transaction outstanding at most.
REQ-006 IDLE: cmd_ready=1; on cmd_valid&cmd_ready SHALL latch the address and go to AR.
REQ-007 AR: arvalid=1; araddr SHALL be {latched_addr[31:3],3'b000}; on arready go to R. Nothing else SHALL change while arvalid=1 and arready=0.
REQ-008 Constant AR fields: arid=NC_ARID, arlen=0, arsize=3'b011, arburst=2'b01, arlock=0, arcache=4'b0000, arprot=3'b100.
REQ-009 R: rready=1; on rvalid SHALL latch rdata and set err=rresp[1] (SLVERR/DECERR=1; OKAY/EXOKAY=0), then go to RESP. rlast is not checked.
REQ-010 RESP: resp_valid=1, rdata/err held stable; on resp_ready go to IDLE.
REQ-011 cmd_ready SHALL be 0 in AR, R and RESP; rready SHALL be 0 outside R; rvalid seen outside R SHALL be ignored and not consumed.
REQ-012 Latency: a command accepted in cycle N SHALL raise arvalid in N+1; an R beat accepted in cycle M SHALL raise resp_valid in M+1. Minimum round trip is 4 cycles.
REQ-013 All handshake outputs SHALL be registered or decoded directly from the state register; no combinational path from any input to any output.
REQ-014 A new command SHALL NOT be accepted in the cycle resp completes (IDLE is entered first).

Reset
REQ-015 During reset: state=IDLE; cmd_ready=1; arvalid, rready, resp_valid, resp_err = 0; araddr and resp_rdata = 0.
REQ-016 Assertion of reset mid-transaction SHALL abandon it immediately; no response SHALL be produced for it after reset is released.

Structure
REQ-017 FSM state encoding typedef and the AXI constants (burst INCR, size 8B, prot instruction) SHALL live in srv_constant; AXI_IW comes from srv_parameter.
REQ-018 SHALL be a single flat module with no sub-modules.

Verification
REQ-019 Basic: cmd addr 0x8000_0014 -> araddr 0x8000_0010, arlen 0, arsize 3; rdata 0x1122334455667788 with rresp OKAY -> resp_rdata matches, err 0, 4 cycles from cmd to resp with no stalls.
REQ-020 AR stall: arready held low 5 cycles -> arvalid and araddr stable; cmd_ready 0 throughout.
REQ-021 Error: rresp 2'b10 and then 2'b11 -> resp_err 1 each time; rresp 2'b01 -> resp_err 0.
REQ-022 Back-pressure: resp_ready low 3 cycles -> resp_valid, rdata and err stable; cmd_valid held high is not accepted until the cycle after the resp handshake.
REQ-023 Reset in R state -> all outputs at reset values; after release, a late rvalid is not consumed (rready 0) and no resp_valid appears.
